// File: rtl/sar_search_pkg.sv
// Shared types and constants for the successive-approximation search block.
// State encoding, comparator-latency range and the latency counter width.
package sar_search_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sar_state_e;

    // Supported comparator latency range (cycles from guess change to valid flags).
    localparam int CMP_LAT_MIN = 1;
    localparam int CMP_LAT_MAX = 4;

    // Counter wide enough to hold CMP_LAT_MAX.
    localparam int LAT_CNT_W = $clog2(CMP_LAT_MAX + 1);

endpackage

// File: rtl/sar_search_if.sv
// Bundle between the SAR search engine (master) and its environment (slave):
// the start/busy/done/result control group plus the comparator bus.
//
// Handshake: start is a level request that is only sampled while the engine
// is IDLE; busy is high from the accepting edge until the edge that raises
// done; done is a single-cycle pulse qualifying result/found/err. The
// comparator flags carry no valid of their own: the engine samples them only
// at its internal sample point and ignores them at all other times.
interface sar_search_if #(
    parameter int WIDTH = 8
);
    import sar_search_pkg::*;

    logic             start;
    logic             cmp_gt;
    logic             cmp_ls;
    logic             cmp_eq;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;
    sar_state_e       state_dbg;

    modport master (
        input  start, cmp_gt, cmp_ls, cmp_eq,
        output guess, busy, done, result, found, err, state_dbg
    );

    modport slave (
        output start, cmp_gt, cmp_ls, cmp_eq,
        input  guess, busy, done, result, found, err, state_dbg
    );

endinterface

// File: rtl/sar_lat_timer.sv
// Comparator latency timer: a down-counter reloaded with CMP_LAT whenever a
// new guess is launched; strobe is high once the count has reached zero.
module sar_lat_timer
    import sar_search_pkg::*;
#(
    parameter int CMP_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic strobe
);

    localparam logic [LAT_CNT_W-1:0] LOAD_VAL = LAT_CNT_W'(CMP_LAT);

    logic [LAT_CNT_W-1:0] cnt_q;
    logic [LAT_CNT_W-1:0] cnt_d;

    // Reload on a new guess, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strobe = (cnt_q == '0);

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search engine. Drives a registered guess into an
// external comparator and resolves one bit per CMP_LAT+1 cycles, MSB first,
// to find the largest value <= the comparator's target.
// Optional build macro: SAR_EARLY_EXIT_EN -- finish as soon as an equality
// is seen instead of always walking all WIDTH bits.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CMP_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    sar_search_if.master bus
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    sar_state_e       state_q,  state_d;
    logic [WIDTH-1:0] guess_q,  guess_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q,  found_d;
    logic             err_q,    err_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             timer_load;
    logic             sample_stb;
    logic             flags_ok;
    logic             eq_hit;
    logic             early_exit;
    logic [IDX_W-1:0] idx_dec;
    logic [WIDTH-1:0] next_mask;
    logic [WIDTH-1:0] kept_acc;

    sar_lat_timer #(
        .CMP_LAT (CMP_LAT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .strobe (sample_stb)
    );

    // Flag decode for the sample point: a trial bit is dropped only on a
    // clean "greater than"; malformed flags keep the bit and raise err.
    always_comb begin
        flags_ok  = $onehot({bus.cmp_gt, bus.cmp_ls, bus.cmp_eq});
        eq_hit    = flags_ok && bus.cmp_eq;
        kept_acc  = (flags_ok && bus.cmp_gt) ? acc_q : guess_q;
        idx_dec   = idx_q - 1'b1;
        next_mask = ONE << idx_dec;
    end

`ifdef SAR_EARLY_EXIT_EN
    assign early_exit = eq_hit;
`else
    assign early_exit = 1'b0;
`endif

    // Next-state and datapath: a new guess is launched on the edge that
    // enters PROBE, so the sample edge of one bit is the launch edge of the next.
    always_comb begin
        state_d    = state_q;
        guess_d    = guess_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        result_d   = result_q;
        found_d    = found_q;
        err_d      = err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timer_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = PROBE;
                    acc_d      = '0;
                    idx_d      = IDX_TOP;
                    guess_d    = TOP_BIT;
                    found_d    = 1'b0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    timer_load = 1'b1;
                end
            end

            PROBE: begin
                state_d = WAIT;
            end

            WAIT: begin
                if (sample_stb) begin
                    err_d = err_q | ~flags_ok;
                    // The guess never reaches zero, so a clean "greater than"
                    // on the last bit with nothing kept means target == 0.
                    found_d = found_q | eq_hit
                            | ((idx_q == '0) && flags_ok && bus.cmp_gt && (acc_q == '0));
                    acc_d = kept_acc;
                    if (early_exit) begin
                        result_d = guess_q;
                        state_d  = DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else if (idx_q == '0) begin
                        result_d = kept_acc;
                        state_d  = DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d      = idx_dec;
                        guess_d    = kept_acc | next_mask;
                        timer_load = 1'b1;
                        state_d    = PROBE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any in-flight search.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.guess     = guess_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.found     = found_q;
    assign bus.err       = err_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search (WIDTH=8, CMP_LAT=1) with a registered comparator
// model. Expected results, probe sequences and latencies come from a
// reference model of bisection over the target value.
module tb_sar_search;
    import sar_search_pkg::*;

`ifdef SAR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [7:0] result;
        logic       found;
        logic       err;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] target;
    bit         bad;

    exp_t       exp_q[$];
    logic [7:0] exp_guess_q[$];

    int n_checks;
    int n_pass;
    int busy_cnt;
    exp_t mon_e;

    sar_search_if #(.WIDTH(8)) bus ();

    sar_search #(
        .WIDTH   (8),
        .CMP_LAT (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator model: registered flags, one cycle of latency.
    always @(posedge clk) begin
        if (bad) begin
            bus.cmp_gt <= 1'b1;
            bus.cmp_ls <= 1'b1;
            bus.cmp_eq <= 1'b0;
        end else begin
            bus.cmp_gt <= (bus.guess > target);
            bus.cmp_ls <= (bus.guess < target);
            bus.cmp_eq <= (bus.guess == target);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Reference model: bisection probes for target t, optionally stopping
    // after max_probes (aborted search) without an expected result.
    task automatic push_search(input logic [7:0] t, input bit bad_flags, input int max_probes);
        int   ti;
        int   stop_b;
        int   lat;
        int   cnt;
        exp_t e;
        ti     = int'(t);
        stop_b = 0;
        lat    = 16;
        if (EARLY && ti != 0) begin
            for (int b = 7; b >= 0; b--) begin
                if (ti[b]) stop_b = b;
            end
            lat = 2 * (8 - stop_b);
        end
        cnt = 0;
        for (int b = 7; b >= stop_b; b--) begin
            if (cnt < max_probes) begin
                exp_guess_q.push_back(8'(((ti >> (b + 1)) << (b + 1)) | (1 << b)));
            end
            cnt++;
        end
        if (max_probes >= 8) begin
            e.result = t;
            e.found  = 1'b1;
            e.err    = bad_flags;
            e.lat    = lat;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (!bus.busy && !bus.done && bus.state_dbg == IDLE) return;
        end
        fail("wait_idle");
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) return;
        end
        fail("wait_done");
    endtask

    // Issue one search; returns 1 time unit after the accepting edge.
    task automatic run_search(input logic [7:0] t, input bit bad_flags, input int max_probes);
        wait_idle();
        target = t;
        push_search(t, bad_flags, max_probes);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (bad_flags) begin
            bad = 1'b1;
            @(posedge clk);
            #1;
            bad = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_guess"},  32'(bus.guess),     32'h0);
        check({tag, "_busy"},   32'(bus.busy),      32'h0);
        check({tag, "_done"},   32'(bus.done),      32'h0);
        check({tag, "_result"}, 32'(bus.result),    32'h0);
        check({tag, "_found"},  32'(bus.found),     32'h0);
        check({tag, "_err"},    32'(bus.err),       32'h0);
        check({tag, "_state"},  32'(bus.state_dbg), 32'(IDLE));
    endtask

    // Scoreboard monitor: checks every probed guess and every done pulse.
    always @(negedge clk) begin
        if (bus.state_dbg == PROBE) begin
            if (exp_guess_q.size() == 0) fail("guess_unexpected");
            else check("guess", 32'(bus.guess), 32'(exp_guess_q.pop_front()));
        end
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                fail("done_unexpected");
            end else begin
                mon_e = exp_q.pop_front();
                check("result",  32'(bus.result), 32'(mon_e.result));
                check("found",   32'(bus.found),  32'(mon_e.found));
                check("err",     32'(bus.err),    32'(mon_e.err));
                check("latency", 32'(busy_cnt),   32'(mon_e.lat));
                check("busy_at_done", 32'(bus.busy), 32'h0);
            end
        end
        if (rst || bus.done) busy_cnt = 0;
        else if (bus.busy) busy_cnt++;
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        busy_cnt  = 0;
        bad       = 1'b0;
        target    = 8'h00;
        rst       = 1'b1;
        bus.start = 1'b1;

        // Reset with start asserted alongside: start must be discarded.
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        @(negedge clk);
        check("start_with_rst_dropped", 32'(bus.busy), 32'h0);

        // Directed targets, including both boundaries.
        run_search(8'h5A, 1'b0, 8);
        check("busy_after_accept", 32'(bus.busy), 32'h1);
        wait_done();
        run_search(8'h00, 1'b0, 8);
        wait_done();
        run_search(8'hFF, 1'b0, 8);
        wait_done();
        run_search(8'h80, 1'b0, 8);
        wait_done();

        // Malformed flags at the first sample: err sticky until next start.
        run_search(8'($urandom_range(8'h81, 8'hFF)), 1'b1, 8);
        wait_done();
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(bus.err), 32'h1);
        run_search(8'($urandom_range(1, 255)), 1'b0, 8);
        check("err_cleared_on_start", 32'(bus.err), 32'h0);
        wait_done();

        // Reset in cycle 5 of a search, then a normal search.
        run_search(8'h33, 1'b0, 3);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        check("midreset_probes_seen", 32'(exp_guess_q.size()), 32'h0);
        run_search(8'($urandom_range(0, 255)), 1'b0, 8);
        wait_done();

        // start while busy and while in DONE has no effect.
        run_search(8'($urandom_range(0, 255)), 1'b0, 8);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", 32'(bus.busy), 32'h0);
        check("idle_after_done", 32'(bus.state_dbg), 32'(IDLE));

        // Random targets.
        for (int i = 0; i < 20; i++) begin
            run_search(8'($urandom_range(0, 255)), 1'b0, 8);
            wait_done();
        end

        wait_idle();
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("exp_guess_q_drained", 32'(exp_guess_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter: WIDTH, 8, bit width of the searched value.
REQ-002 Parameter: CMP_LAT, 1, cycles from a guess change to valid comparator flags (1..4).
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: start  in  1  request a new search; sampled only in IDLE.
REQ-006 Port: cmp_gt  in  1  comparator flag, guess > target.
REQ-007 Port: cmp_ls  in  1  comparator flag, guess < target.
REQ-008 Port: cmp_eq  in  1  comparator flag, guess == target.
REQ-009 Port: guess  out  WIDTH  registered trial value driven to the comparator's a operand.
REQ-010 Port: busy  out  1  high from the start accept until the done pulse.
REQ-011 Port: done  out  1  one-cycle pulse when the result is final.
REQ-012 Port: result  out  WIDTH  largest value <= target; held until the next start.
REQ-013 Port: found  out  1  an equality was observed during the search; held with result.
REQ-014 Port: err  out  1  sticky; flags were not one-hot at a sample point; cleared by start or rst.

Function
REQ-015 The block is the initiator side of the comparator interface: it drives guess and consumes gt/ls/eq.
REQ-016 States: IDLE, PROBE, WAIT, DONE; IDLE->PROBE on start, PROBE->WAIT, WAIT->PROBE or DONE, DONE->IDLE after one cycle.
REQ-017 On start in IDLE: clear the accumulator, found and err; bit index = WIDTH-1; busy=1 next cycle.
REQ-018 PROBE: guess <= accumulator | (1 << index).
REQ-019 Flags are sampled exactly CMP_LAT+1 edges after the guess update; each bit costs CMP_LAT+1 cycles.
REQ-020 At the sample point: cmp_gt clears the bit; cmp_ls or cmp_eq keeps the bit; cmp_eq also sets found.
REQ-021 After bit 0 is evaluated: result <= accumulator, enter DONE, done=1 for exactly one cycle, busy=0 in the same cycle.
REQ-022 Flags that are zero or multi-hot at a sample point set err; the bit is kept; the search continues.
REQ-023 start while busy or in DONE is ignored; there is no queueing.
REQ-024 Flags outside sample points are ignored.
REQ-025 Boundaries: target 0 gives result 0 and found=1 on the last probe; target 2^WIDTH-1 gives all ones.

Reset
REQ-026 rst overrides everything, including mid-search.
REQ-027 After rst: state=IDLE, guess=0, busy=0, done=0, result=0, found=0, err=0.
REQ-028 start asserted in the same cycle as rst is discarded.

Configuration
REQ-029 The macro is SAR_EARLY_EXIT_EN.
REQ-030 Defined: cmp_eq at a sample point loads result <= current guess and enters DONE immediately.
REQ-031 Undefined: all WIDTH bits are always evaluated, giving fixed latency WIDTH*(CMP_LAT+1) cycles from start accept to done; the result is identical.

Structure
REQ-032 A shared package holds the state enum (IDLE, PROBE, WAIT, DONE) and the CMP_LAT range constants.
REQ-033 Sub-module sar_lat_timer: a down-counter loaded with CMP_LAT in PROBE that asserts the sample strobe at zero.

Verification
REQ-034 The bench instantiates a comparator model with registered flags (CMP_LAT=1) driven by guess and a target register; WIDTH=8.
REQ-035 Target 0x5A, macro off -> done exactly 16 cycles after start accept, result=0x5A, found=1, err=0.
REQ-036 Targets 0x00 and 0xFF -> result 0x00 and 0xFF respectively; found=1 in both cases.
REQ-037 Target 0x80, macro on -> done 2 cycles after start accept, result=0x80, found=1.
REQ-038 Force cmp_gt=cmp_ls=1 at the first sample -> err=1 and remains 1 until the next start.
REQ-039 rst asserted at cycle 5 of a search -> all outputs at reset values next cycle; a new start completes normally.
REQ-040 start pulsed while busy=1 -> no effect on guess sequence or done timing.
